// File: rtl/axis_ring_addr_gen.sv
// axis_ring_addr_gen
//   Frames a tlast-delimited AXI-Stream into a circular byte buffer. For each
//   frame it presents a start address and a constant maximum burst length to
//   the downstream writer, and passes the beats straight through. Frames longer
//   than the maximum are cut short: out_tlast is forced on the last allowed beat
//   and the rest of the frame is dropped. The block tracks how many ring bytes
//   are in use. It holds off new frames until the reader has released enough
//   space, and it emits one descriptor for every committed frame.
//
// Ports
//   clock, rst        single clock, synchronous active-high reset
//   in_t*             upstream stream (data, keep, valid, last, ready)
//   out_t*            stream to the writer (last is forced on truncation)
//   addr              start byte address of the current frame
//   max_length        maximum frame length in beats (constant)
//   desc_valid/addr/span  one-cycle descriptor pulse for a committed frame
//   rel_valid/rel_bytes   reader hands back ring space
//   fill              occupied ring bytes
//   overflow_err      one-cycle pulse when a frame was truncated
//   rel_err           one-cycle pulse when a release exceeded the fill level

module axis_ring_addr_gen #(
    parameter int unsigned DSIZE           = 64,
    parameter logic [31:0] BASE_ADDR       = 32'h1000_0000,
    parameter int unsigned RING_BYTES      = 2**24,
    parameter int unsigned FRAME_MAX_BYTES = 4096
) (
    input  logic                        clock,
    input  logic                        rst,
    input  logic [DSIZE-1:0]            in_tdata,
    input  logic [DSIZE/8-1:0]          in_tkeep,
    input  logic                        in_tvalid,
    input  logic                        in_tlast,
    output logic                        in_tready,
    output logic [DSIZE-1:0]            out_tdata,
    output logic [DSIZE/8-1:0]          out_tkeep,
    output logic                        out_tvalid,
    output logic                        out_tlast,
    input  logic                        out_tready,
    output logic [31:0]                 addr,
    output logic [31:0]                 max_length,
    output logic                        desc_valid,
    output logic [31:0]                 desc_addr,
    output logic [31:0]                 desc_span,
    input  logic                        rel_valid,
    input  logic [31:0]                 rel_bytes,
    output logic [$clog2(RING_BYTES):0] fill,
    output logic                        overflow_err,
    output logic                        rel_err
);

    localparam int unsigned FW        = $clog2(RING_BYTES) + 1;
    localparam logic [31:0] BPB       = 32'(DSIZE / 8);
    localparam logic [31:0] MAX_LEN   = 32'(FRAME_MAX_BYTES / (DSIZE / 8));
    localparam logic [31:0] RING      = 32'(RING_BYTES);
    localparam logic [31:0] FRAME_MAX = 32'(FRAME_MAX_BYTES);

    typedef enum logic [1:0] {IDLE, PASS, DROP} state_t;

    state_t      state;
    logic [31:0] wr_ptr;
    logic [31:0] skip_r;
    logic [31:0] beat_cnt;

    logic [31:0] off;
    logic [31:0] room;
    logic [31:0] skip_now;
    logic [31:0] free_bytes;
    logic        start_ok;
    logic        accept;
    logic        last_beat;
    logic        commit;
    logic [31:0] frame_bytes;
    logic [31:0] commit_span;
    logic [31:0] end_ptr;
    logic [31:0] next_ptr;
    logic [31:0] rel_amt;
    logic [32:0] fill_plus;
    logic        fill_under;

    assign max_length = MAX_LEN;

    // Frame admission and commit arithmetic. A frame always needs a full
    // FRAME_MAX_BYTES window. If the tail of the ring is shorter than that,
    // the tail is skipped, and the skipped bytes are charged to this frame's
    // span so that the reader releases them along with the frame.
    always_comb begin
        off         = wr_ptr - BASE_ADDR;
        room        = RING - off;
        skip_now    = (room < FRAME_MAX) ? room : 32'd0;
        free_bytes  = RING - 32'(fill);
        start_ok    = in_tvalid && (free_bytes >= skip_now + FRAME_MAX);
        accept      = (state == PASS) && in_tvalid && out_tready;
        last_beat   = in_tlast || (beat_cnt == MAX_LEN - 32'd1);
        commit      = accept && last_beat;
        frame_bytes = (beat_cnt + 32'd1) * BPB;
        commit_span = skip_r + frame_bytes;
        end_ptr     = addr + frame_bytes;
        next_ptr    = (end_ptr - BASE_ADDR >= RING) ? BASE_ADDR : end_ptr;
        rel_amt     = rel_valid ? rel_bytes : 32'd0;
        fill_plus   = 33'(fill) + (commit ? {1'b0, commit_span} : 33'd0);
        fill_under  = {1'b0, rel_amt} > fill_plus;
    end

    // Stream handshake. Beats flow straight through only while a frame is
    // open. In DROP, beats are swallowed until the upstream tlast arrives.
    always_comb begin
        out_tdata  = in_tdata;
        out_tkeep  = in_tkeep;
        out_tvalid = (state == PASS) && in_tvalid;
        out_tlast  = (state == PASS) && last_beat;
        case (state)
            PASS:    in_tready = out_tready;
            DROP:    in_tready = 1'b1;
            default: in_tready = 1'b0;
        endcase
    end

    // Frame FSM plus the bookkeeping registers. A commit and a release that
    // land in the same cycle are both applied to fill. A release that drives
    // fill below zero clamps fill to zero and is flagged.
    always_ff @(posedge clock) begin
        if (rst) begin
            state        <= IDLE;
            wr_ptr       <= BASE_ADDR;
            addr         <= BASE_ADDR;
            skip_r       <= 32'd0;
            beat_cnt     <= 32'd0;
            fill         <= '0;
            desc_valid   <= 1'b0;
            desc_addr    <= 32'd0;
            desc_span    <= 32'd0;
            overflow_err <= 1'b0;
            rel_err      <= 1'b0;
        end else begin
            desc_valid   <= commit;
            overflow_err <= 1'b0;
            rel_err      <= fill_under;
            fill         <= fill_under ? '0 : FW'(fill_plus - {1'b0, rel_amt});
            if (commit) begin
                desc_addr <= addr;
                desc_span <= commit_span;
                wr_ptr    <= next_ptr;
            end
            case (state)
                IDLE: begin
                    if (start_ok) begin
                        addr     <= (skip_now != 32'd0) ? BASE_ADDR : wr_ptr;
                        skip_r   <= skip_now;
                        beat_cnt <= 32'd0;
                        state    <= PASS;
                    end
                end
                PASS: begin
                    if (accept) begin
                        beat_cnt <= beat_cnt + 32'd1;
                        if (last_beat) begin
                            if (in_tlast) begin
                                state <= IDLE;
                            end else begin
                                state        <= DROP;
                                overflow_err <= 1'b1;
                            end
                        end
                    end
                end
                DROP: begin
                    if (in_tvalid && in_tlast) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
